// File: rtl/alu_arbiter_if.sv
// Bundles the two requester ports, the shared-ALU drive and return, and the response port.
// The arbiter connects through the slave modport; the environment connects through master.
interface alu_arbiter_if #(
  parameter int BUS_WIDTH = 32
);
  logic                 req0_valid;
  logic                 req1_valid;
  logic                 req0_ready;
  logic                 req1_ready;
  logic [3:0]           req0_opcode;
  logic [3:0]           req1_opcode;
  logic [BUS_WIDTH-1:0] req0_num_0;
  logic [BUS_WIDTH-1:0] req0_num_1;
  logic [BUS_WIDTH-1:0] req1_num_0;
  logic [BUS_WIDTH-1:0] req1_num_1;

  logic [3:0]           alu_opcode;
  logic [BUS_WIDTH-1:0] alu_num_0;
  logic [BUS_WIDTH-1:0] alu_num_1;
  logic [BUS_WIDTH-1:0] alu_num_out;
  logic                 alu_over_flag;
  logic                 alu_zero_flag;
  logic                 alu_greater_flag;
  logic                 alu_equal_flag;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_id;
  logic                 rsp_err;
  logic [BUS_WIDTH-1:0] rsp_num_out;
  logic [3:0]           rsp_flags;

  modport slave (
    input  req0_valid, req1_valid, req0_opcode, req1_opcode,
           req0_num_0, req0_num_1, req1_num_0, req1_num_1,
           alu_num_out, alu_over_flag, alu_zero_flag, alu_greater_flag, alu_equal_flag,
           rsp_ready,
    output req0_ready, req1_ready,
           alu_opcode, alu_num_0, alu_num_1,
           rsp_valid, rsp_id, rsp_err, rsp_num_out, rsp_flags
  );

  modport master (
    output req0_valid, req1_valid, req0_opcode, req1_opcode,
           req0_num_0, req0_num_1, req1_num_0, req1_num_1,
           alu_num_out, alu_over_flag, alu_zero_flag, alu_greater_flag, alu_equal_flag,
           rsp_ready,
    input  req0_ready, req1_ready,
           alu_opcode, alu_num_0, alu_num_1,
           rsp_valid, rsp_id, rsp_err, rsp_num_out, rsp_flags
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each operation runs IDLE (accept) -> EXEC (ALU settles) -> RESP (held until rsp_ready).
module alu_arbiter #(
  parameter int BUS_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_arbiter_if.slave bus
);

  localparam logic [3:0] OP_NUL = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic                 r_last_grant;
  logic                 r_pend_id;
  logic                 r_pend_err;
  logic [3:0]           r_alu_opcode;
  logic [BUS_WIDTH-1:0] r_alu_num_0;
  logic [BUS_WIDTH-1:0] r_alu_num_1;
  logic                 r_rsp_valid;
  logic                 r_rsp_id;
  logic                 r_rsp_err;
  logic [BUS_WIDTH-1:0] r_rsp_num_out;
  logic [3:0]           r_rsp_flags;

  logic                 w_any_valid;
  logic                 w_grant;
  logic                 w_accept;
  logic [3:0]           w_sel_opcode;
  logic [BUS_WIDTH-1:0] w_sel_num_0;
  logic [BUS_WIDTH-1:0] w_sel_num_1;
  logic                 w_sel_legal;

  function automatic logic is_legal(input logic [3:0] op);
    return (op == OP_NUL) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_XOR) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_grant     = 1'b0;
    w_any_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) w_grant = ~r_last_grant;
    else if (bus.req1_valid)              w_grant = 1'b1;
  end

  // Ready is held low while reset is asserted even though the state already reads IDLE.
  assign w_accept       = rst_n && (r_state == IDLE) && w_any_valid;
  assign bus.req0_ready = w_accept && !w_grant;
  assign bus.req1_ready = w_accept &&  w_grant;

  assign w_sel_opcode = w_grant ? bus.req1_opcode : bus.req0_opcode;
  assign w_sel_num_0  = w_grant ? bus.req1_num_0  : bus.req0_num_0;
  assign w_sel_num_1  = w_grant ? bus.req1_num_1  : bus.req0_num_1;
  assign w_sel_legal  = is_legal(w_sel_opcode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next_state = EXEC;
      EXEC:    w_next_state = RESP;
      RESP:    if (bus.rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // The requester id and error bit wait in r_pend_* so rsp_* only move at the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_last_grant  <= 1'b1;
      r_pend_id     <= 1'b0;
      r_pend_err    <= 1'b0;
      r_alu_opcode  <= OP_NUL;
      r_alu_num_0   <= '0;
      r_alu_num_1   <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_rsp_num_out <= '0;
      r_rsp_flags   <= 4'b0000;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_alu_opcode <= w_sel_legal ? w_sel_opcode : OP_NUL;
            r_alu_num_0  <= w_sel_num_0;
            r_alu_num_1  <= w_sel_num_1;
            r_pend_id    <= w_grant;
            r_pend_err   <= !w_sel_legal;
            r_last_grant <= w_grant;
          end
        end
        EXEC: begin
          r_rsp_valid  <= 1'b1;
          r_rsp_id     <= r_pend_id;
          r_rsp_err    <= r_pend_err;
          r_alu_opcode <= OP_NUL;
          if (r_pend_err) begin
            r_rsp_num_out <= '0;
            r_rsp_flags   <= 4'b0000;
          end else begin
            r_rsp_num_out <= bus.alu_num_out;
            r_rsp_flags   <= {bus.alu_over_flag, bus.alu_zero_flag,
                              bus.alu_greater_flag, bus.alu_equal_flag};
          end
        end
        RESP: begin
          if (bus.rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_opcode  = r_alu_opcode;
  assign bus.alu_num_0   = r_alu_num_0;
  assign bus.alu_num_1   = r_alu_num_1;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_id      = r_rsp_id;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_num_out = r_rsp_num_out;
  assign bus.rsp_flags   = r_rsp_flags;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester 0/1 has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  request accepted this cycle when valid&ready.
REQ-006 SHALL have ports req0_opcode / req1_opcode  input  4  ALU command.
REQ-007 SHALL have ports req0_num_0, req0_num_1, req1_num_0, req1_num_1  input  BUS_WIDTH  operands.
REQ-008 SHALL have ports alu_opcode  output  4, alu_num_0 / alu_num_1  output  BUS_WIDTH  registered drive to the shared ALU.
REQ-009 SHALL have ports alu_num_out  input  BUS_WIDTH; alu_over_flag, alu_zero_flag, alu_greater_flag, alu_equal_flag  input  1  ALU results (combinational from ALU inputs).
REQ-010 SHALL have ports rsp_valid  output  1; rsp_ready  input  1; rsp_id  output  1 (serving requester); rsp_err  output  1 (illegal opcode); rsp_num_out  output  BUS_WIDTH; rsp_flags  output  4  {over, zero, greater, equal}.

Function
REQ-011 SHALL recognise legal opcodes NUL 4'b0000, ADD 4'b0001, SUB 4'b0010, XOR 4'b0011, AND 4'b0100, OR 4'b1000; all others illegal.
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-013 IDLE: grant computed combinationally; reqN_ready = (state==IDLE) && grant==N; other ready 0; no ready in EXEC/RESP.
REQ-014 Round-robin: one valid -> grant it; both valid -> grant requester not in last_grant; last_grant reset value 1 (requester 0 wins first tie).
REQ-015 On accept edge: latch opcode/operands into alu_* regs, record rsp_id, update last_grant, go EXEC.
REQ-016 Illegal opcode on accept: alu_opcode loaded NUL, operands loaded as given, err bit set; timing identical to legal op.
REQ-017 EXEC (exactly one cycle): at its closing edge capture alu_num_out and flags into rsp_num_out/rsp_flags, set rsp_valid=1, alu_opcode<=NUL, go RESP.
REQ-018 If err set, capture forces rsp_num_out=0, rsp_flags=4'b0000, rsp_err=1; else rsp_err=0.
REQ-019 Latency: accept at edge T -> rsp_valid high after edge T+1 (first response cycle = second cycle after accept).
REQ-020 RESP: hold rsp_* stable while rsp_ready=0 (unbounded backpressure); on edge with rsp_ready=1 clear rsp_valid, go IDLE.
REQ-021 Throughput: max one operation per 3 cycles; new accept no earlier than the cycle after response handshake.
REQ-022 alu_num_0/alu_num_1 SHALL hold last values outside accept edge; alu_opcode SHALL be NUL in IDLE and RESP.
REQ-023 Requester deasserting valid before ready SHALL not be granted; no request is lost once accepted.
REQ-024 rsp_num_out, rsp_flags, rsp_id, rsp_err SHALL change only at the EXEC capture edge.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, last_grant 1, rsp_valid 0, rsp_id 0, rsp_err 0, rsp_num_out 0, rsp_flags 0, alu_opcode NUL, alu_num_0 0, alu_num_1 0, req0_ready/req1_ready 0 while asserted.
REQ-026 Reset in EXEC or RESP SHALL discard the in-flight operation; no response produced after release.
REQ-027 First accept possible at first rising edge after rst_n deassertion.

Verification
REQ-028 Single: req0 ADD 0xfffffff1, 0x00000001 -> req0_ready same cycle; alu_opcode 0001 next cycle; rsp_valid after 2 edges, rsp_num_out 0xfffffff2, rsp_id 0, rsp_err 0, flags = ALU flags.
REQ-029 Tie: both valid from reset, req0 SUB 0x0000ffff-0x0000ffff, req1 AND 0x7e7e7e7e,0x5555aaaa, rsp_ready=1 -> responses id 0 (num_out 0, zero flag 1) then id 1 (0x54542a2a); repeated ties alternate 0,1,0,1.
REQ-030 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_* constant, both ready 0, alu_opcode NUL; rsp_ready=1 -> IDLE next edge.
REQ-031 Illegal: req1 opcode 4'b0111 -> alu_opcode NUL in EXEC, rsp_err 1, rsp_num_out 0, rsp_flags 0000, rsp_id 1.
REQ-032 Reset mid-op: rst_n low during EXEC -> all outputs at reset values immediately, no rsp_valid after release; next req0 XOR 0xfffffff1,0x0000000f -> 0xfffffffe, id 0.
